// File: rtl/bk8_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// bk8_addsub_pipe_if
// Bundles the two valid/ready channels of the 8-bit add/subtract pipeline.
//
// Signals:
//   in_valid  / in_ready   : request handshake (producer -> adder)
//   in_a, in_b             : 8-bit operands
//   in_sub                 : 1 = a - b, 0 = a + b
//   in_tag                 : sideband tag returned with the result
//   out_valid / out_ready  : response handshake (adder -> consumer)
//   out_res                : 8-bit sum/difference, modulo 256
//   out_cout               : carry out of bit 7 (for subtract, 1 = no borrow)
//   out_ovf                : signed overflow
//   out_tag                : tag belonging to out_res
//
// Modports:
//   master : the environment driving requests and consuming responses
//   slave  : the adder pipeline itself
// ---------------------------------------------------------------------------
interface bk8_addsub_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_res;
    logic             out_cout;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_cout, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_cout, out_ovf, out_tag
    );
endinterface

// File: rtl/bk8_addsub_pipe.sv
// ---------------------------------------------------------------------------
// bk8_addsub_pipe
// 8-bit two's-complement add/subtract unit using a Brent-Kung prefix carry
// tree, split over two register stages with valid/ready flow control.
//   S1 registers per-bit generate/propagate (carry-in folded into bit 0).
//   S2 evaluates the prefix tree and registers result, carry and overflow.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset; discards all in-flight operations
//   bus    : bk8_addsub_pipe_if.slave, request and response channels
//
// Parameters:
//   TAG_W  : sideband tag width (1..16), must match the interface instance
// ---------------------------------------------------------------------------
module bk8_addsub_pipe #(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bk8_addsub_pipe_if.slave  bus
);

    // Stage 1 state
    logic             s1_v;
    logic [7:0]       s1_g;
    logic [7:0]       s1_p;
    logic             s1_cin;
    logic             s1_a7;
    logic             s1_bb7;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 state
    logic             s2_v;
    logic [7:0]       s2_res;
    logic             s2_cout;
    logic             s2_ovf;
    logic [TAG_W-1:0] s2_tag;

    // Flow control
    logic s2_adv;
    logic s1_adv;

    // Stage 1 combinational inputs
    logic [7:0] bb;
    logic [7:0] g_in;
    logic [7:0] p_in;

    // Prefix tree nodes: gXY/pXY is the group (generate, propagate) for bits X..Y.
    // Groups that reach bit 0 only need a generate, since carry-in is already
    // merged into bit 0.
    logic       g10, g32, p32, g54, p54, g76, p76;
    logic       g30, g74, p74;
    logic       g70;
    logic       g50;
    logic       g20, g40, g60;
    logic [7:0] c;
    logic [7:0] res;
    logic       ovf;

    // A stage may load whenever it is empty or the stage downstream frees up,
    // so a full pipe still streams at one operation per cycle.
    always_comb begin
        s2_adv       = ~s2_v | bus.out_ready;
        s1_adv       = ~s1_v | s2_adv;
        bus.in_ready = s1_adv;
    end

    // Subtraction uses a + ~b + 1; the +1 is absorbed into bit-0 generate so
    // the carry tree itself never needs a separate carry-in input.
    always_comb begin
        bb      = bus.in_sub ? ~bus.in_b : bus.in_b;
        p_in    = bus.in_a ^ bb;
        g_in    = bus.in_a & bb;
        g_in[0] = g_in[0] | (p_in[0] & bus.in_sub);
    end

    // Stage 1 register: captures operands only on an input transfer and
    // otherwise holds while S2 cannot accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_g   <= '0;
            s1_p   <= '0;
            s1_cin <= 1'b0;
            s1_a7  <= 1'b0;
            s1_bb7 <= 1'b0;
            s1_tag <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_g   <= g_in;
                s1_p   <= p_in;
                s1_cin <= bus.in_sub;
                s1_a7  <= bus.in_a[7];
                s1_bb7 <= bb[7];
                s1_tag <= bus.in_tag;
            end
        end
    end

    // Brent-Kung tree: up-sweep builds spans of 2, 4, 8 at the odd bits,
    // down-sweep fills bit 5 and then the even bits from their neighbours.
    always_comb begin
        // up-sweep, span 2
        g10 = s1_g[1] | (s1_p[1] & s1_g[0]);
        g32 = s1_g[3] | (s1_p[3] & s1_g[2]);
        p32 = s1_p[3] & s1_p[2];
        g54 = s1_g[5] | (s1_p[5] & s1_g[4]);
        p54 = s1_p[5] & s1_p[4];
        g76 = s1_g[7] | (s1_p[7] & s1_g[6]);
        p76 = s1_p[7] & s1_p[6];
        // up-sweep, span 4
        g30 = g32 | (p32 & g10);
        g74 = g76 | (p76 & g54);
        p74 = p76 & p54;
        // up-sweep, span 8
        g70 = g74 | (p74 & g30);
        // down-sweep
        g50 = g54 | (p54 & g30);
        g20 = s1_g[2] | (s1_p[2] & g10);
        g40 = s1_g[4] | (s1_p[4] & g30);
        g60 = s1_g[6] | (s1_p[6] & g50);

        c   = {g70, g60, g50, g40, g30, g20, g10, s1_g[0]};
        res = s1_p ^ {c[6:0], s1_cin};
        ovf = (s1_a7 == s1_bb7) & (res[7] != s1_a7);
    end

    // Stage 2 register: holds the presented result until the consumer takes
    // it; drains to empty when S1 has nothing to hand over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_res  <= '0;
            s2_cout <= 1'b0;
            s2_ovf  <= 1'b0;
            s2_tag  <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_res  <= res;
                s2_cout <= c[7];
                s2_ovf  <= ovf;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Outputs come straight from S2 so nothing on the input side reaches them
    // combinationally.
    always_comb begin
        bus.out_valid = s2_v;
        bus.out_res   = s2_res;
        bus.out_cout  = s2_cout;
        bus.out_ovf   = s2_ovf;
        bus.out_tag   = s2_tag;
    end

endmodule

// File: tb/tb_bk8_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_bk8_addsub_pipe
// Scoreboard bench for bk8_addsub_pipe: the driver pushes the arithmetic
// expectation for each accepted operation, the monitor pops and compares on
// every output transfer and also checks that stalled outputs hold steady.
// ---------------------------------------------------------------------------
module tb_bk8_addsub_pipe;

    localparam int TAG_W = 4;

    typedef struct {
        logic [7:0]       res;
        logic             cout;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    bit   expectLat;
    bit   toggleDone;
    exp_t sbq[$];

    bk8_addsub_pipe_if #(.TAG_W(TAG_W)) ifc ();

    bk8_addsub_pipe #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Free-running clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Hard stop in case something never terminates
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference arithmetic: plain integer add/subtract on unsigned and signed views
    function automatic exp_t model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub;
            sr     = sa + sb;
            e.cout = (r > 255);
        end
        e.res = r[7:0];
        e.ovf = (sr > 127) || (sr < -128);
        e.tag = tag;
        e.acc = 0;
        return e;
    endfunction

    // Presents one operation and waits until it is accepted; called #1 after a
    // rising edge and returns #1 after the accepting edge with in_valid still high.
    task automatic applyStimulus(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic [TAG_W-1:0] tag);
        exp_t e;
        int   n;
        ifc.in_valid = 1'b1;
        ifc.in_sub   = sub;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_tag   = tag;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifc.in_ready) begin
                e     = model(sub, a, b, tag);
                e.acc = cyc;
                sbq.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                checkOutput("accept_timeout", 32'(n), 32'd0);
                return;
            end
        end
    endtask

    task automatic idle();
        ifc.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: output transfers are scored against the queue; a stalled
    // output must be unchanged at the next sample.
    logic [14:0] prevOut;
    bit          prevStall;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_stable",
                            32'({ifc.out_valid, ifc.out_res, ifc.out_cout, ifc.out_ovf, ifc.out_tag}),
                            32'(prevOut));
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_output", 32'(ifc.out_tag) + 32'h100, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("res",  32'(ifc.out_res),  32'(e.res));
                    checkOutput("cout", 32'(ifc.out_cout), 32'(e.cout));
                    checkOutput("ovf",  32'(ifc.out_ovf),  32'(e.ovf));
                    checkOutput("tag",  32'(ifc.out_tag),  32'(e.tag));
                    if (expectLat) begin
                        checkOutput("latency", 32'(cyc - e.acc), 32'd2);
                    end
                end
            end
            prevStall = ifc.out_valid && !ifc.out_ready;
            prevOut   = {ifc.out_valid, ifc.out_res, ifc.out_cout, ifc.out_ovf, ifc.out_tag};
        end
    end

    task automatic checkResetState();
        checkOutput("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        checkOutput("rst_out_res",   32'(ifc.out_res),   32'd0);
        checkOutput("rst_out_cout",  32'(ifc.out_cout),  32'd0);
        checkOutput("rst_out_ovf",   32'(ifc.out_ovf),   32'd0);
        checkOutput("rst_out_tag",   32'(ifc.out_tag),   32'd0);
        checkOutput("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    endtask

    initial begin
        logic [7:0]       ra, rb, bv;
        logic [TAG_W-1:0] tg;
        int               bi;
        int               sent;

        checks        = 0;
        failures      = 0;
        cyc           = 0;
        expectLat     = 1'b0;
        prevStall     = 1'b0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_sub    = 1'b0;
        ifc.in_tag    = '0;
        ifc.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState();
        @(posedge clk);
        #1;

        // Directed arithmetic cases, unstalled
        $display("[TB] directed cases");
        expectLat = 1'b1;
        applyStimulus(1'b1, 8'h05, 8'h03, 4'h1);
        applyStimulus(1'b1, 8'h03, 8'h05, 4'h2);
        applyStimulus(1'b1, 8'h80, 8'h01, 4'h3);
        applyStimulus(1'b0, 8'hFF, 8'h01, 4'h4);
        applyStimulus(1'b0, 8'h7F, 8'h01, 4'h5);
        applyStimulus(1'b1, 8'h00, 8'h00, 4'h6);
        applyStimulus(1'b1, 8'h00, 8'h80, 4'h7);
        applyStimulus(1'b1, 8'h7F, 8'h80, 4'h8);
        applyStimulus(1'b1, 8'h80, 8'h80, 4'h9);
        idle();
        waitDrain();

        // Back-to-back random stream, tags 0..15
        $display("[TB] random stream");
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(1'($urandom), ra, rb, 4'(i));
        end
        idle();
        waitDrain();

        // Backpressure: consumer stalls for 5 cycles while the producer keeps pushing
        $display("[TB] backpressure");
        expectLat     = 1'b0;
        ifc.out_ready = 1'b0;
        sent          = 0;
        for (int c = 0; c < 5; c++) begin
            ifc.in_valid = 1'b1;
            ifc.in_sub   = 1'($urandom);
            ifc.in_a     = 8'($urandom);
            ifc.in_b     = 8'($urandom);
            ifc.in_tag   = 4'(sent);
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(ifc.in_ready), (c < 2) ? 32'd1 : 32'd0);
            if (ifc.in_ready) begin
                sbq.push_back(model(ifc.in_sub, ifc.in_a, ifc.in_b, ifc.in_tag));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b1;
        for (int i = sent; i < 8; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 4'(i));
        end
        idle();
        waitDrain();

        // Random consumer readiness while a stream is offered
        $display("[TB] random out_ready");
        toggleDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 4'(i));
                end
                idle();
                toggleDone = 1'b1;
            end
            begin
                while (!toggleDone) begin
                    @(posedge clk);
                    #1;
                    ifc.out_ready = 1'($urandom);
                end
            end
        join
        ifc.out_ready = 1'b1;
        waitDrain();

        // Reset while full and stalled
        $display("[TB] reset mid-stall");
        ifc.out_ready = 1'b0;
        applyStimulus(1'b0, 8'h12, 8'h34, 4'hA);
        applyStimulus(1'b1, 8'h56, 8'h78, 4'hB);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        @(negedge clk);
        checkResetState();
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Sweep over both operations, every A and a quarter of B values
        $display("[TB] sweep");
        expectLat = 1'b1;
        tg = '0;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a++) begin
                for (int j = 0; j < 64; j++) begin
                    bi = j * 4 + ((a + s) % 4);
                    bv = bi[7:0];
                    ra = a[7:0];
                    applyStimulus(s[0], ra, bv, tg);
                    tg = tg + 1'b1;
                end
            end
        end
        idle();
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
